// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - register indices, exception codes and field offsets for cp0_nested
package cp0_pkg;

  // CP0 register indices
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  // ExcCodes used by the control unit
  typedef enum logic [4:0] {
    EXC_INT = 5'd0,
    EXC_SYS = 5'd8,
    EXC_BP  = 5'd9,
    EXC_TEQ = 5'd13
  } exc_code_e;

  localparam int EXC_W   = 5;   // ExcCode width
  localparam int EXC_LSB = 2;   // Cause.ExcCode lsb
  localparam int IP_LSB  = 8;   // Cause.IP lsb
  localparam int IM_LSB  = 24;  // Status.IM lsb

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare timer with prescaler and sticky pending flag
//  clk, rst_n         clock, async active-low reset
//  count_we, wdata    mtc0 Count: load Count, clear prescaler, no increment/match this cycle
//  compare_we         mtc0 Compare: load Compare, clear pending
//  count, compare     current register values
//  pend               sticky timer pending
module cp0_timer #(
  parameter int DATA_W    = 32,
  parameter int TIMER_DIV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              count_we,
  input  logic              compare_we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] count,
  output logic [DATA_W-1:0] compare,
  output logic              pend
);

  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;

  logic [PW-1:0]     presc_q, presc_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] compare_q, compare_d;
  logic              pend_q, pend_d;
  logic              tick;

  always_comb begin
    presc_d   = presc_q;
    count_d   = count_q;
    compare_d = compare_q;
    pend_d    = pend_q;
    tick      = (presc_q == PW'(TIMER_DIV - 1));
    if (count_we) begin
      count_d = wdata;
      presc_d = '0;
    end else begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        count_d = count_q + DATA_W'(1);
        // match is evaluated only on the increment, so a parked Count
        // equal to Compare does not re-arm after software clears pend
        if (count_d == compare_q) pend_d = 1'b1;
      end
    end
    // writing Compare acknowledges the timer, even against a same-cycle match
    if (compare_we) begin
      compare_d = wdata;
      pend_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '1;
      pend_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      pend_q    <= pend_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign pend    = pend_q;

endmodule

// File: rtl/cp0_nested.sv
// rtl/cp0_nested.sv - coprocessor 0 with nested status stack, masked irqs and timer
//  clk, rst_n              clock, async active-low reset
//  mfc0, mtc0, rd_sel      register read/write strobes and index
//  wdata                   mtc0 data
//  pc, exception, cause    exception entry: faulting PC and ExcCode
//  eret                    exception return
//  irq                     asynchronous level interrupt lines
//  rdata                   mfc0 data (0 when not reading)
//  status                  Status register
//  exc_addr                EPC during eret, handler vector otherwise
//  intr_req                interrupt request to control unit
//  timer_int               timer pending
//  nest_overflow           pulse after an entry taken at full nesting depth
module cp0_nested
  import cp0_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter int                NUM_IRQ    = 6,
  parameter int                FIELD_W    = 5,
  parameter int                NEST_DEPTH = 3,
  parameter logic [DATA_W-1:0] EXC_VECTOR = 32'h00400004,
  parameter int                TIMER_DIV  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mfc0,
  input  logic               mtc0,
  input  logic [4:0]         rd_sel,
  input  logic [DATA_W-1:0]  wdata,
  input  logic [DATA_W-1:0]  pc,
  input  logic               exception,
  input  logic [4:0]         cause,
  input  logic               eret,
  input  logic [NUM_IRQ-1:0] irq,
  output logic [DATA_W-1:0]  rdata,
  output logic [DATA_W-1:0]  status,
  output logic [DATA_W-1:0]  exc_addr,
  output logic               intr_req,
  output logic               timer_int,
  output logic               nest_overflow
);

  localparam int SW = FIELD_W * (NEST_DEPTH + 1);
  localparam int IW = NUM_IRQ + 1;
  localparam int LW = $clog2(NEST_DEPTH + 1);
  localparam logic [SW-1:0] STACK_RST = SW'((1 << FIELD_W) - 1);

  logic [SW-1:0]      stack_q, stack_d;
  logic [IW-1:0]      im_q, im_d;
  logic [LW-1:0]      level_q, level_d;
  logic [EXC_W-1:0]   exc_code_q, exc_code_d;
  logic [DATA_W-1:0]  epc_q, epc_d;
  logic               ovf_q, ovf_d;
  logic [NUM_IRQ-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

  logic [DATA_W-1:0]  count_val, compare_val, cause_val;
  logic               timer_pend;
  logic [IW-1:0]      ip;

  cp0_timer #(
    .DATA_W    (DATA_W),
    .TIMER_DIV (TIMER_DIV)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_we   (mtc0 && (rd_sel == CP0_COUNT)),
    .compare_we (mtc0 && (rd_sel == CP0_COMPARE)),
    .wdata      (wdata),
    .count      (count_val),
    .compare    (compare_val),
    .pend       (timer_pend)
  );

  assign ip = {timer_pend, sync2_q};

  always_comb begin
    status                 = '0;
    status[SW-1:0]         = stack_q;
    status[IM_LSB +: IW]   = im_q;
    cause_val              = '0;
    cause_val[EXC_LSB +: EXC_W] = exc_code_q;
    cause_val[IP_LSB +: IW]     = ip;
  end

  assign intr_req      = stack_q[0] & (|(ip & im_q));
  assign exc_addr      = eret ? epc_q : EXC_VECTOR;
  assign timer_int     = timer_pend;
  assign nest_overflow = ovf_q;

  always_comb begin
    rdata = '0;
    if (mfc0) begin
      case (rd_sel)
        CP0_COUNT:   rdata = count_val;
        CP0_COMPARE: rdata = compare_val;
        CP0_STATUS:  rdata = status;
        CP0_CAUSE:   rdata = cause_val;
        CP0_EPC:     rdata = epc_q;
        default:     rdata = '0;
      endcase
    end
  end

  // Only one of mtc0 / exception / eret is taken per edge, in that order.
  // An mtc0 to any index (including Count/Compare) blocks the other two.
  always_comb begin
    stack_d    = stack_q;
    im_d       = im_q;
    level_d    = level_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    ovf_d      = 1'b0;
    sync1_d    = irq;
    sync2_d    = sync1_q;
    if (mtc0) begin
      case (rd_sel)
        CP0_STATUS: begin
          stack_d = wdata[SW-1:0];
          im_d    = wdata[IM_LSB +: IW];
        end
        CP0_CAUSE: exc_code_d = wdata[EXC_LSB +: EXC_W];
        CP0_EPC:   epc_d      = wdata;
        default:   ;
      endcase
    end else if (exception) begin
      stack_d    = stack_q << FIELD_W;
      ovf_d      = (level_q == LW'(NEST_DEPTH));
      if (level_q != LW'(NEST_DEPTH)) level_d = level_q + LW'(1);
      exc_code_d = cause;
      epc_d      = pc;
    end else if (eret) begin
      stack_d = stack_q >> FIELD_W;
      if (level_q != '0) level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stack_q    <= STACK_RST;
      im_q       <= '1;
      level_q    <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
      ovf_q      <= 1'b0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      stack_q    <= stack_d;
      im_q       <= im_d;
      level_q    <= level_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
      ovf_q      <= ovf_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
    end
  end

endmodule
